pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised, elastic inter-stage pipeline register; successor to the fixed decode/execute latch.
- Carries NUM_OPS operand words plus a CTRL_W control bundle (ALU op, write enable, mux selects, ...) between any two pipeline stages.
- Adds valid/ready handshaking, a 2-entry skid buffer so in_ready is a pure register output, and a synchronous flush that turns the stage into a bubble.

Parameters:
- DATA_W, 32, width of one operand word.
- NUM_OPS, 3, operand words per transfer (e.g. rs1, rs2, imm).
- CTRL_W, 9, width of the control bundle.
- CNT_W, 16, width of the performance counters (used only with PIPE_PERF_EN).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- in_valid  in  1  upstream presents a transfer.
- in_ready  out  1  stage can accept a transfer; registered output.
- in_ops  in  NUM_OPS*DATA_W  operands; word k at bits [k*DATA_W +: DATA_W].
- in_ctrl  in  CTRL_W  control bundle.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  stage holds a transfer for downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_ops  out  NUM_OPS*DATA_W  registered operands.
- out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0.
- perf_clr  in  1  clears the counters (PIPE_PERF_EN only).
- stall_cnt  out  CNT_W  stall-cycle count (PIPE_PERF_EN only).
- bubble_cnt  out  CNT_W  bubble-cycle count (PIPE_PERF_EN only).

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid, in_ready, skid_valid = 0.
  - out_ops, out_ctrl, skid contents = 0.
  - in_ready rises on the first clk edge after reset releases.
- Handshake:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - Payload must stay stable while valid is high and ready is low; the stage guarantees this on its output.
- Latency: 1 cycle. Data accepted at edge N appears on out_* after edge N when the main slot is free or emitting.
- Storage: a main slot (drives out_*) and a skid slot.
- States, encoded by {out_valid, skid_valid}:
  - EMPTY (0,0): accept goes to main, giving ONE.
  - ONE (1,0):
    - Accept & emit: main is overwritten; stays ONE.
    - Accept & !emit: entry goes to skid, giving FULL; in_ready=0 next cycle.
    - Emit only: EMPTY.
  - FULL (1,1):
    - in_ready=0, so no accept.
    - Emit: skid moves to main, giving ONE; in_ready=1 next cycle.
  - (0,1) is illegal and never reachable.
- in_ready next = !(next skid_valid), registered.
- Throughput is 1 transfer/cycle when out_ready is held high.
- Flush:
  - Next state is EMPTY; out_ctrl = 0 and skid ctrl = 0.
  - out_ops and skid ops hold their values (not cleared, to save power).
  - in_ready = 1 on the next cycle.
  - Flush has priority over a same-cycle accept: that transfer is dropped. Upstream must treat the cycle as consumed.
- Ordering is strictly FIFO; main is always older than skid.
- Reset asserted mid-transfer: all entries are lost immediately and there is no partial output.

Optional Feature:
- Macro: PIPE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with !out_valid.
  - Both saturate at 2^CNT_W-1.
  - Both are cleared by reset (asynchronous) or perf_clr (synchronous, priority over increment).
  - Flush does not clear them.
- Undefined: perf_clr is ignored, stall_cnt and bubble_cnt are tied to 0, and no counter flops are inferred.

Decomposition:
- pipe_pkg holds:
  - DATA_W_DEF=32 and CTRL_W_DEF=9.
  - A typedef struct packed ctrl_t {alu_op[2:0], we, data_in_s, data_in_on, opb_sel, sel_mem, spare} matching CTRL_W_DEF.
  - A sat_inc function used by the counters.
- One sub-module, pipe_slot: a single payload register with load enable and a synchronous ctrl-clear. It is instantiated twice (main, skid).

Test Plan:
- Reset release, then in_valid=1, in_ops={3,2,1}, in_ctrl=9'h0A5, out_ready=1 -> in_ready=1 on the first edge after release; out_valid=1 with the same payload one cycle after accept.
- Stream of 8 transfers, ops=i, out_ready=1 -> 8 outputs in order 0..7 on consecutive cycles; in_ready never drops.
- out_ready=0 with transfers A then B -> A on out_* and B in skid; in_ready=0. Raise out_ready -> A emitted, then B, and in_ready=1 one cycle after A leaves.
- FULL state plus flush=1 with in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C is never emitted.
- Drive reset=0 asynchronously between edges while in ONE -> out_valid and out_ctrl go to 0 immediately, without waiting for clk.
- PIPE_PERF_EN with out_valid=1, out_ready=0 for 5 cycles, then idle for 3 cycles -> stall_cnt=5 and bubble_cnt=3. Then perf_clr -> both 0. With CNT_W=2 -> counters saturate at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline stage (pipe_stage_skid).
// Counter saturation helper is used only when PIPE_PERF_EN is defined.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 9;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       we;
        logic       data_in_s;
        logic       data_in_on;
        logic       opb_sel;
        logic       sel_mem;
        logic       spare;
    } ctrl_t;

    // Encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } slot_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        if (value >= max_value) begin
            return max_value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the skid stage: load enable plus a synchronous
// ctrl clear that leaves the operand bits untouched.
module pipe_slot #(
    parameter int OPS_W  = 96,
    parameter int CTRL_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clr_ctrl,
    input  logic [OPS_W-1:0]  d_ops,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [OPS_W-1:0]  q_ops,
    output logic [CTRL_W-1:0] q_ctrl
);

    // Payload register; clearing ctrl wins over a load in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_ops  <= {OPS_W{1'b0}};
            q_ctrl <= {CTRL_W{1'b0}};
        end else if (clr_ctrl) begin
            q_ctrl <= {CTRL_W{1'b0}};
        end else if (load) begin
            q_ops  <= d_ops;
            q_ctrl <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic inter-stage register with a 2-entry skid buffer and flush.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_OPS = 3,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [CTRL_W-1:0]         out_ctrl,
    input  logic                      perf_clr,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
);

    localparam int OPS_W = NUM_OPS * DATA_W;

    slot_state_t       state_r;
    slot_state_t       state_nxt_s;
    logic              in_ready_r;
    logic              accept_s;
    logic              emit_s;
    logic              main_load_s;
    logic              main_from_skid_s;
    logic              skid_load_s;
    logic              main_clr_s;
    logic              skid_clr_s;
    logic [OPS_W-1:0]  main_d_ops_s;
    logic [CTRL_W-1:0] main_d_ctrl_s;
    logic [OPS_W-1:0]  skid_ops_s;
    logic [CTRL_W-1:0] skid_ctrl_s;

    assign out_valid = state_r[1];
    assign in_ready  = in_ready_r;
    assign accept_s  = in_valid & in_ready_r;
    assign emit_s    = out_valid & out_ready;

    // Next-state and slot load decisions; flush overrides any accept.
    always_comb begin
        state_nxt_s      = state_r;
        main_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ST_ONE;
                        main_load_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && emit_s) begin
                        main_load_s = 1'b1;
                    end else if (accept_s) begin
                        skid_load_s = 1'b1;
                        state_nxt_s = ST_FULL;
                    end else if (emit_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (emit_s) begin
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        state_nxt_s      = ST_ONE;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Empty slots are forced to zero ctrl so out_ctrl is zero without out_valid.
    assign main_clr_s    = flush | (state_nxt_s == ST_EMPTY);
    assign skid_clr_s    = flush | (state_nxt_s != ST_FULL);
    assign main_d_ops_s  = main_from_skid_s ? skid_ops_s  : in_ops;
    assign main_d_ctrl_s = main_from_skid_s ? skid_ctrl_s : in_ctrl;

    // Occupancy state and registered in_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_EMPTY;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s != ST_FULL);
        end
    end

    pipe_slot #(.OPS_W(OPS_W), .CTRL_W(CTRL_W)) u_main (
        .clk      (clk),
        .reset    (reset),
        .load     (main_load_s),
        .clr_ctrl (main_clr_s),
        .d_ops    (main_d_ops_s),
        .d_ctrl   (main_d_ctrl_s),
        .q_ops    (out_ops),
        .q_ctrl   (out_ctrl)
    );

    pipe_slot #(.OPS_W(OPS_W), .CTRL_W(CTRL_W)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load_s),
        .clr_ctrl (skid_clr_s),
        .d_ops    (in_ops),
        .d_ctrl   (in_ctrl),
        .q_ops    (skid_ops_s),
        .q_ctrl   (skid_ctrl_s)
    );

`ifdef PIPE_PERF_EN
    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;

    // Saturating stall/bubble counters; perf_clr beats increment, flush ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (perf_clr) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt_r <= CNT_W'(sat_inc(32'(stall_cnt_r), CNT_MAX));
            end
            if (!out_valid) begin
                bubble_cnt_r <= CNT_W'(sat_inc(32'(bubble_cnt_r), CNT_MAX));
            end
        end
    end

    assign stall_cnt  = stall_cnt_r;
    assign bubble_cnt = bubble_cnt_r;
`else
    logic unused_perf_clr_s;

    assign unused_perf_clr_s = perf_clr;
    assign stall_cnt         = {CNT_W{1'b0}};
    assign bubble_cnt        = {CNT_W{1'b0}};
`endif

endmodule
